// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART frame transmitter that clears the SEND bit of its control register
// through a one-cycle write strobe. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ctrl_i,
  input  logic [31:0] data_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        wr_send_o,
  output logic [31:0] ctrl_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CLEANUP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY  = 3'd5;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             wr_send_q, wr_send_d;
  logic [31:0]      ctrl_q, ctrl_d;
  logic             bit_done;
  logic             unused_data_hi;

  assign bit_done       = (cnt_q == CNT_LAST);
  assign unused_data_hi = ^data_i[31:8];

  // Frame sequencing; the register write-back is captured on the STOP->CLEANUP edge.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    wr_send_d = 1'b0;
    ctrl_d    = ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_i[0]) begin
          data_d  = data_i[7:0];
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          state_d   = ST_CLEANUP;
          wr_send_d = 1'b1;
          ctrl_d    = {ctrl_i[31:1], 1'b0};
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_CLEANUP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter restarts on every state change and every bit boundary.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_IDLE) || bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Line level is decoded from the next state so the flop shows it together with that state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    tx_d   = 1'b1;
    case (state_d)
      ST_IDLE:    tx_d = 1'b1;
      ST_START:   tx_d = 1'b0;
      ST_DATA:    tx_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY:  tx_d = even_parity(data_q);
`endif
      ST_STOP:    tx_d = 1'b1;
      ST_CLEANUP: tx_d = 1'b1;
      default:    tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_send_q <= 1'b0;
      ctrl_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_send_q <= wr_send_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign wr_send_o = wr_send_q;
  assign ctrl_o    = ctrl_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at CLKS_PER_BIT=4; expected line levels and
// write-back values are queued when a frame is requested and compared as the frame completes.
module tb_uart_tx_engine;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] ctrl_i;
  logic [31:0] data_i;
  logic        tx_o;
  logic        busy_o;
  logic        wr_send_o;
  logic [31:0] ctrl_o;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;

  logic        exp_bits[$];
  logic [31:0] exp_ctrl[$];

  logic        cap_tx[$];
  int          cap_busy_low;
  int          cap_wr_frame;
  logic        cap_wr_cleanup;
  logic        cap_tx_cleanup;
  logic        cap_busy_cleanup;
  logic [31:0] cap_ctrl_cleanup;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .ctrl_i    (ctrl_i),
    .data_i    (data_i),
    .tx_o      (tx_o),
    .busy_o    (busy_o),
    .wr_send_o (wr_send_o),
    .ctrl_o    (ctrl_o)
  );

  task automatic push_frame(input logic [7:0] d, input logic [31:0] c);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
    exp_bits.push_back(1'b1);
    exp_ctrl.push_back({c[31:1], 1'b0});
  endtask

  // Called at a negedge with the DUT idle and SEND already driven; records one whole frame.
  task automatic capture_frame(input int drop_at, input int chg_at, input logic [31:0] chg_data);
    cap_tx.delete();
    cap_busy_low = 0;
    cap_wr_frame = 0;
    @(posedge clk);
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      cap_tx.push_back(tx_o);
      if (busy_o !== 1'b1) cap_busy_low++;
      if (wr_send_o !== 1'b0) cap_wr_frame++;
      if (c == drop_at) ctrl_i[0] = 1'b0;
      if (c == chg_at) data_i = chg_data;
    end
    @(negedge clk);
    cap_wr_cleanup   = wr_send_o;
    cap_tx_cleanup   = tx_o;
    cap_busy_cleanup = busy_o;
    cap_ctrl_cleanup = ctrl_o;
  endtask

  task automatic test_reset();
    rst_i  = 1'b0;
    ctrl_i = 32'h0000_0001;
    data_i = 32'h0000_00FF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: tx_o=%b busy_o=%b expected tx_o=1 busy_o=0", tx_o, busy_o);
    end
    n_checks++;
    if (wr_send_o !== 1'b0 || ctrl_o !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_wr: wr_send_o=%b ctrl_o=%h expected 0 / 00000000", wr_send_o, ctrl_o);
    end
    ctrl_i = 32'h0000_0000;
    rst_i  = 1'b1;
  endtask

  task automatic test_idle();
    ctrl_i = 32'hFFFF_FFFE;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || wr_send_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold cyc%0d: tx_o=%b busy_o=%b wr_send_o=%b expected 1/0/0",
                 c, tx_o, busy_o, wr_send_o);
      end
    end
    ctrl_i = 32'h0000_0000;
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [31:0] c,
                            input int drop_at, input int chg_at, input logic [31:0] chg_data);
    logic        eb;
    logic [31:0] ec;
    int          bad;
    data_i = {24'h000000, d};
    ctrl_i = c;
    push_frame(d, c);
    capture_frame(drop_at, chg_at, chg_data);
    for (int b = 0; b < NBITS; b++) begin
      eb  = exp_bits.pop_front();
      bad = 0;
      for (int k = 0; k < CPB; k++) begin
        if (cap_tx[b*CPB + k] !== eb) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s bit%0d: tx_o first sample %b, %0d of %0d samples wrong, expected %b",
                 name, b, cap_tx[b*CPB], bad, CPB, eb);
      end
    end
    ec = exp_ctrl.pop_front();
    n_checks++;
    if (cap_busy_low != 0 || cap_wr_frame != 0) begin
      n_fail++;
      $display("FAIL %s_body: busy_o low %0d cycles, wr_send_o high %0d cycles, expected 0/0",
               name, cap_busy_low, cap_wr_frame);
    end
    n_checks++;
    if (cap_wr_cleanup !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_strobe: wr_send_o=%b in cleanup, expected 1", name, cap_wr_cleanup);
    end
    n_checks++;
    if (cap_ctrl_cleanup !== ec) begin
      n_fail++;
      $display("FAIL %s_ctrl: ctrl_o=%h expected %h", name, cap_ctrl_cleanup, ec);
    end
    n_checks++;
    if (cap_tx_cleanup !== 1'b1 || cap_busy_cleanup !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_cleanup: tx_o=%b busy_o=%b expected 1/1", name, cap_tx_cleanup,
               cap_busy_cleanup);
    end
    wr_seen += cap_wr_frame + ((cap_wr_cleanup === 1'b1) ? 1 : 0);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1 || wr_send_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: busy_o=%b tx_o=%b wr_send_o=%b after frame, expected 0/1/0",
               name, busy_o, tx_o, wr_send_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wrc;
    wrc    = 0;
    data_i = 32'h0000_00A5;
    ctrl_i = 32'h0000_0001;
    @(posedge clk);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (wr_send_o !== 1'b0) wrc++;
    end
    n_checks++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_bit3: tx_o=%b in data bit 3 of A5, expected 0", tx_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || wr_send_o !== 1'b0 || ctrl_o !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL midrst_abort: tx_o=%b busy_o=%b wr_send_o=%b ctrl_o=%h expected 1/0/0/0",
               tx_o, busy_o, wr_send_o, ctrl_o);
    end
    n_checks++;
    if (wrc != 0) begin
      n_fail++;
      $display("FAIL midrst_nostrobe: %0d wr_send_o pulses before abort, expected 0", wrc);
    end
    wr_seen += wrc;
    rst_i = 1'b1;
    test_frame("after_reset", 8'hA5, 32'h0000_0001, 0, -1, 32'h0);
  endtask

  task automatic test_back_to_back();
    int wr0;
    wr0 = wr_seen;
    test_frame("b2b_first", 8'hC3, 32'h0000_0101, -1, -1, 32'h0);
    test_frame("b2b_second", 8'h3C, 32'h0000_0101, 0, -1, 32'h0);
    n_checks++;
    if (wr_seen - wr0 != 2) begin
      n_fail++;
      $display("FAIL b2b_strobes: %0d wr_send_o pulses, expected 2", wr_seen - wr0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame("frame55", 8'h55, 32'h0000_0001, 0, -1, 32'h0);
    test_frame("ctrl_msb", 8'h07, 32'h8000_0001, 0, -1, 32'h0);
    test_frame("data_chg", 8'hA5, 32'h0000_0001, 0, 12, 32'h0000_00FF);
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, giving clk_i cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all logic on posedge.
REQ-003 The block SHALL have port rst_i, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port ctrl_i, input, 32, current control register value; bit0 = SEND request, other bits opaque.
REQ-005 The block SHALL have port data_i, input, 32, TX data register; bits [7:0] are the byte to send.
REQ-006 The block SHALL have port tx_o, output, 1, serial line, idle high.
REQ-007 The block SHALL have port busy_o, output, 1, high while a frame is in progress.
REQ-008 The block SHALL have port wr_send_o, output, 1, one-cycle write strobe to the control register's hardware write port.
REQ-009 The block SHALL have port ctrl_o, output, 32, value written with wr_send_o: ctrl_i with bit0 cleared.

Function
REQ-010 The block SHALL use states IDLE, START, DATA, PARITY (macro only), STOP, CLEANUP.
REQ-011 In IDLE with ctrl_i[0]=1, the block SHALL latch data_i[7:0], enter START and assert busy_o on the next edge.
REQ-012 In IDLE with ctrl_i[0]=0, the block SHALL hold tx_o=1, busy_o=0, wr_send_o=0.
REQ-013 START SHALL drive tx_o=0 for exactly CLKS_PER_BIT cycles.
REQ-014 DATA SHALL drive the 8 latched bits LSB first, each for exactly CLKS_PER_BIT cycles, using a 3-bit index wrapping 7->0 on exit.
REQ-015 STOP SHALL drive tx_o=1 for exactly CLKS_PER_BIT cycles, then enter CLEANUP.
REQ-016 On STOP->CLEANUP, wr_send_o SHALL assert for exactly one cycle, with ctrl_o = {ctrl_i[31:1],1'b0} sampled in that cycle.
REQ-017 CLEANUP SHALL last one cycle with busy_o=1 and tx_o=1, then enter IDLE, giving the register one edge to commit the clear.
REQ-018 Changes to ctrl_i or data_i during a frame SHALL NOT affect the frame in progress.
REQ-019 If ctrl_i[0] is still 1 in IDLE after CLEANUP (CPU write won priority over the clear), a new frame SHALL start; this is intended behaviour.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and reset to 0 on every state change.
REQ-021 tx_o SHALL be driven from a flop with no combinational glitches.
REQ-022 Frame length SHALL be (10 or 11)*CLKS_PER_BIT + 1 cycles from the SEND-sampled edge to IDLE re-entry.

Reset
REQ-023 With rst_i=0 at a clock edge: state=IDLE, tx_o=1, busy_o=0, wr_send_o=0, ctrl_o=0, counters=0, data latch=0.
REQ-024 Reset mid-frame SHALL abort the frame with no wr_send_o pulse; tx_o SHALL be 1 from the edge after reset.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL insert PARITY between DATA and STOP for CLKS_PER_BIT cycles, driving even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-026 Without UART_TX_PARITY_EN, no PARITY state or logic SHALL exist; DATA goes directly to STOP; frame = 10 bits.

Verification
REQ-027 CLKS_PER_BIT=4, no macro, data_i=0x55, ctrl_i=0x1 pulse -> tx_o=0,1,0,1,0,1,0,1,0,1 each held 4 cycles, 1 wr_send_o pulse, ctrl_o=0x0.
REQ-028 UART_TX_PARITY_EN, data_i=0x07, ctrl_i=0x8000_0001 -> parity bit=1, stop=1, ctrl_o=0x8000_0000, frame 45 cycles.
REQ-029 rst_i=0 during DATA bit 3 -> tx_o=1 next edge, busy_o=0, no wr_send_o pulse; ctrl_i[0] held 1 after reset -> a fresh frame starts.
REQ-030 Change data_i 0xA5->0xFF mid-DATA -> transmitted byte remains 0xA5.
REQ-031 ctrl_i[0] held 1 across CLEANUP (register does not clear) -> second frame starts one cycle after CLEANUP; two wr_send_o pulses total.
